hazard_ctrl: RTL and testbench

Parametrised hazard controller for the 5-stage RV32 pipeline: detects load-use hazards against a configurable load latency, generates operand forwarding selects, and flushes on taken branches. A per-register pending-load scoreboard replaces single-cycle load-use detection, so one unit covers 1..4-cycle data memories. Sits beside the ID stage. It drives the PC/IF-ID enables, the ID/EX bubble, the flushes and the EX operand muxes.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_ctrl_if.sv | 66 ++++++
 rtl/load_scoreboard.sv | 55 +++++
 rtl/hazard_ctrl.sv | 109 ++++++++++
 tb/tb_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // EX operand source select. MEM is the youngest producer, WB the next.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Deepest data-memory latency the scoreboard counters can express.
  localparam int LOAD_LAT_MAX = 4;

  // Width of each per-register pending-load counter.
  localparam int PEND_W = 3;

  // Observation bundle: the internal decisions behind the control outputs.
  typedef struct packed {
    logic load_set;   // EX load is being recorded in the scoreboard this cycle
    logic haz_rs1;    // ID rs1 depends on an in-flight load
    logic haz_rs2;    // ID rs2 depends on an in-flight load
    logic stall;      // load-use stall asserted this cycle
  } hz_dbg_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: ID/EX/MEM/WB register
// fields in, stall/flush/forward controls out.
//
// There is no valid/ready handshake on this bundle. Every *_valid and
// *_reg_write input is a level qualifier for its stage in the current cycle;
// the controls coming back are combinational answers for the same cycle and
// take effect at the next clock edge in the pipeline registers.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  import hazard_pkg::*;

  // ID stage
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;

  // EX stage
  logic              ex_valid;
  logic              ex_mem_read;
  logic              ex_reg_write;
  logic [REG_AW-1:0] ex_rd;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic              ex_branch_taken;

  // MEM / WB stages
  logic              mem_reg_write;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd;

  // Controls back to the pipeline
  logic              pc_en;
  logic              ifid_en;
  logic              idex_bubble;
  logic              flush_ifid;
  fwd_sel_e          fwd_a;
  fwd_sel_e          fwd_b;
  logic [CNT_W-1:0]  stall_count;
  hz_dbg_t           dbg;

  // Pipeline side
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_valid, ex_mem_read, ex_reg_write, ex_rd, ex_rs1, ex_rs2,
    output ex_branch_taken,
    output mem_reg_write, mem_rd, wb_reg_write, wb_rd,
    input  pc_en, ifid_en, idex_bubble, flush_ifid, fwd_a, fwd_b,
    input  stall_count, dbg
  );

  // Hazard controller side
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_valid, ex_mem_read, ex_reg_write, ex_rd, ex_rs1, ex_rs2,
    input  ex_branch_taken,
    input  mem_reg_write, mem_rd, wb_reg_write, wb_rd,
    output pc_en, ifid_en, idex_bubble, flush_ifid, fwd_a, fwd_b,
    output stall_count, dbg
  );

endinterface

// File: rtl/load_scoreboard.sv
// Per-register pending-load counters. A load leaving EX arms its destination
// counter with LOAD_LAT; every armed counter counts down once per cycle.
// A register still needs to stall a consumer while its counter is >= 2.
module load_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_set,
  input  logic [REG_AW-1:0] load_rd,
  output logic [NREG-1:0]   pend_ge2
);

  // Out-of-range latencies are clamped so the counter width always holds it.
  localparam int LAT_C = (LOAD_LAT < 1) ? 1 :
                         (LOAD_LAT > LOAD_LAT_MAX) ? LOAD_LAT_MAX : LOAD_LAT;
  localparam logic [PEND_W-1:0] LAT_V = PEND_W'(LAT_C);
  localparam logic [PEND_W-1:0] ONE_V = PEND_W'(1);
  localparam logic [PEND_W-1:0] TWO_V = PEND_W'(2);

  logic [PEND_W-1:0] pend [NREG];

  // Counter update: clear on reset, re-arm on a new load (overwrites without
  // decrementing), otherwise count down to zero. x0 never holds a value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        pend[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0) begin
          pend[r] <= '0;
        end else if (load_set && (load_rd == REG_AW'(r))) begin
          pend[r] <= LAT_V;
        end else if (pend[r] != '0) begin
          pend[r] <= pend[r] - ONE_V;
        end
      end
    end
  end

  // A counter of 1 means the value reaches MEM/WB forwarding in time.
  always_comb begin
    pend_ge2 = '0;
    for (int r = 0; r < NREG; r++) begin
      pend_ge2[r] = (pend[r] >= TWO_V);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline. Detects load-use
// dependencies (EX load or scoreboard-pending load), flushes on taken
// branches, selects EX operand forwarding, and counts stall cycles.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input logic           clk,
  input logic           rst,
  hazard_ctrl_if.slave  bus
);

  logic            ex_load;
  logic            load_set;
  logic            haz_rs1;
  logic            haz_rs2;
  logic            stall;
  logic [NREG-1:0] pend_ge2;
  logic [CNT_W-1:0] stall_cnt;
  fwd_sel_e        fwd_a_sel;
  fwd_sel_e        fwd_b_sel;

  // A load always writes rd, so hazard detection keys on ex_mem_read alone.
  logic unused_in;
  assign unused_in = bus.ex_reg_write;

  // A load killed by a taken branch must not leave a pending entry behind.
  assign ex_load  = bus.ex_valid && bus.ex_mem_read;
  assign load_set = ex_load && (bus.ex_rd != '0) && !bus.ex_branch_taken;

  load_scoreboard #(
    .NREG     (NREG),
    .REG_AW   (REG_AW),
    .LOAD_LAT (LOAD_LAT)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .load_set (load_set),
    .load_rd  (bus.ex_rd),
    .pend_ge2 (pend_ge2)
  );

  // Source hazards: the load is in EX right now, or it left EX but its data
  // is still more than one cycle away from the forwarding paths.
  always_comb begin
    haz_rs1 = 1'b0;
    haz_rs2 = 1'b0;
    if (bus.id_use_rs1 && (bus.id_rs1 != '0)) begin
      haz_rs1 = (ex_load && (bus.ex_rd == bus.id_rs1)) || pend_ge2[bus.id_rs1];
    end
    if (bus.id_use_rs2 && (bus.id_rs2 != '0)) begin
      haz_rs2 = (ex_load && (bus.ex_rd == bus.id_rs2)) || pend_ge2[bus.id_rs2];
    end
  end

  // Flush wins over stall: on a taken branch the PC loads the target and
  // the ID instruction is discarded anyway.
  always_comb begin
    stall           = bus.id_valid && (haz_rs1 || haz_rs2) && !bus.ex_branch_taken;
    bus.pc_en       = !stall;
    bus.ifid_en     = !stall;
    bus.idex_bubble = stall || bus.ex_branch_taken;
    bus.flush_ifid  = bus.ex_branch_taken;
  end

  // Operand forwarding: MEM holds the youngest result so it is checked first.
  always_comb begin
    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
    if (bus.mem_reg_write && (bus.mem_rd != '0) && (bus.mem_rd == bus.ex_rs1)) begin
      fwd_a_sel = FWD_MEM;
    end else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == bus.ex_rs1)) begin
      fwd_a_sel = FWD_WB;
    end
    if (bus.mem_reg_write && (bus.mem_rd != '0) && (bus.mem_rd == bus.ex_rs2)) begin
      fwd_b_sel = FWD_MEM;
    end else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == bus.ex_rs2)) begin
      fwd_b_sel = FWD_WB;
    end
  end

  assign bus.fwd_a = fwd_a_sel;
  assign bus.fwd_b = fwd_b_sel;

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_count = stall_cnt;

  // Internal decisions exposed for observation.
  always_comb begin
    bus.dbg          = '0;
    bus.dbg.load_set = load_set;
    bus.dbg.haz_rs1  = haz_rs1;
    bus.dbg.haz_rs2  = haz_rs2;
    bus.dbg.stall    = stall;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: four instances (LOAD_LAT 1, 3, 4 and a narrow
// counter) share one stimulus bus; each check targets the relevant instance.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  typedef struct packed {
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       ex_valid;
    logic       ex_mem_read;
    logic       ex_reg_write;
    logic [4:0] ex_rd;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic       ex_branch_taken;
    logic       mem_reg_write;
    logic [4:0] mem_rd;
    logic       wb_reg_write;
    logic [4:0] wb_rd;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic       pc;
    logic       ifid;
    logic       bub;
    logic       fl;
    logic [1:0] fa;
    logic [1:0] fb;
  } vec_t;

  // clock / reset
  logic  clk = 1'b0;
  logic  rst = 1'b1;
  stim_t st  = '0;
  int    checks   = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) i1 ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) i3 ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) i4 ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(2))  is ();

  assign {i1.id_valid, i1.id_rs1, i1.id_rs2, i1.id_use_rs1, i1.id_use_rs2,
          i1.ex_valid, i1.ex_mem_read, i1.ex_reg_write, i1.ex_rd, i1.ex_rs1, i1.ex_rs2,
          i1.ex_branch_taken, i1.mem_reg_write, i1.mem_rd, i1.wb_reg_write, i1.wb_rd} = st;
  assign {i3.id_valid, i3.id_rs1, i3.id_rs2, i3.id_use_rs1, i3.id_use_rs2,
          i3.ex_valid, i3.ex_mem_read, i3.ex_reg_write, i3.ex_rd, i3.ex_rs1, i3.ex_rs2,
          i3.ex_branch_taken, i3.mem_reg_write, i3.mem_rd, i3.wb_reg_write, i3.wb_rd} = st;
  assign {i4.id_valid, i4.id_rs1, i4.id_rs2, i4.id_use_rs1, i4.id_use_rs2,
          i4.ex_valid, i4.ex_mem_read, i4.ex_reg_write, i4.ex_rd, i4.ex_rs1, i4.ex_rs2,
          i4.ex_branch_taken, i4.mem_reg_write, i4.mem_rd, i4.wb_reg_write, i4.wb_rd} = st;
  assign {is.id_valid, is.id_rs1, is.id_rs2, is.id_use_rs1, is.id_use_rs2,
          is.ex_valid, is.ex_mem_read, is.ex_reg_write, is.ex_rd, is.ex_rs1, is.ex_rs2,
          is.ex_branch_taken, is.mem_reg_write, is.mem_rd, is.wb_reg_write, is.wb_rd} = st;

  hazard_ctrl #(.NREG(32), .REG_AW(5), .LOAD_LAT(1), .CNT_W(32)) dut1 (.clk(clk), .rst(rst), .bus(i1));
  hazard_ctrl #(.NREG(32), .REG_AW(5), .LOAD_LAT(3), .CNT_W(32)) dut3 (.clk(clk), .rst(rst), .bus(i3));
  hazard_ctrl #(.NREG(32), .REG_AW(5), .LOAD_LAT(4), .CNT_W(32)) dut4 (.clk(clk), .rst(rst), .bus(i4));
  hazard_ctrl #(.NREG(32), .REG_AW(5), .LOAD_LAT(4), .CNT_W(2))  dsat (.clk(clk), .rst(rst), .bus(is));

  // driver helpers
  function automatic stim_t mk(input int idv, input int r1, input int r2, input int u1, input int u2,
                               input int exv, input int exmr, input int exrw, input int exrd,
                               input int exrs1, input int exrs2, input int br,
                               input int mrw, input int mrd, input int wrw, input int wrd);
    stim_t s;
    s.id_valid        = 1'(idv);
    s.id_rs1          = 5'(r1);
    s.id_rs2          = 5'(r2);
    s.id_use_rs1      = 1'(u1);
    s.id_use_rs2      = 1'(u2);
    s.ex_valid        = 1'(exv);
    s.ex_mem_read     = 1'(exmr);
    s.ex_reg_write    = 1'(exrw);
    s.ex_rd           = 5'(exrd);
    s.ex_rs1          = 5'(exrs1);
    s.ex_rs2          = 5'(exrs2);
    s.ex_branch_taken = 1'(br);
    s.mem_reg_write   = 1'(mrw);
    s.mem_rd          = 5'(mrd);
    s.wb_reg_write    = 1'(wrw);
    s.wb_rd           = 5'(wrd);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    st  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  vec_t tbl[16];
  stim_t ld5_dep, dep5_idle;

  initial begin
    // load x5 in EX with add x6,x5,x1 in ID; and the same ID with EX empty
    ld5_dep   = mk(1,5,1,1,1, 1,1,1,5,0,0, 0, 0,0,0,0);
    dep5_idle = mk(1,5,1,1,1, 0,0,0,0,0,0, 0, 0,0,0,0);

    tbl[0]  = '{mk(0,0,0,0,0, 0,0,0,0,0,0, 0, 0,0,0,0), 1'b1, 1'b1, 1'b0, 1'b0, FWD_RF,  FWD_RF};
    tbl[1]  = '{mk(1,5,1,1,1, 1,1,1,5,0,0, 0, 0,0,0,0), 1'b0, 1'b0, 1'b1, 1'b0, FWD_RF,  FWD_RF};
    tbl[2]  = '{mk(1,1,5,1,1, 1,1,1,5,0,0, 0, 0,0,0,0), 1'b0, 1'b0, 1'b1, 1'b0, FWD_RF,  FWD_RF};
    tbl[3]  = '{mk(1,5,0,0,0, 1,1,1,5,0,0, 0, 0,0,0,0), 1'b1, 1'b1, 1'b0, 1'b0, FWD_RF,  FWD_RF};
    tbl[4]  = '{mk(1,0,0,1,1, 1,1,1,0,0,0, 0, 0,0,0,0), 1'b1, 1'b1, 1'b0, 1'b0, FWD_RF,  FWD_RF};
    tbl[5]  = '{mk(0,5,1,1,1, 1,1,1,5,0,0, 0, 0,0,0,0), 1'b1, 1'b1, 1'b0, 1'b0, FWD_RF,  FWD_RF};
    tbl[6]  = '{mk(1,5,1,1,1, 1,0,1,5,0,0, 0, 0,0,0,0), 1'b1, 1'b1, 1'b0, 1'b0, FWD_RF,  FWD_RF};
    tbl[7]  = '{mk(1,5,1,1,1, 1,1,1,5,0,0, 1, 0,0,0,0), 1'b1, 1'b1, 1'b1, 1'b1, FWD_RF,  FWD_RF};
    tbl[8]  = '{mk(0,0,0,0,0, 0,0,0,0,0,0, 1, 0,0,0,0), 1'b1, 1'b1, 1'b1, 1'b1, FWD_RF,  FWD_RF};
    tbl[9]  = '{mk(0,0,0,0,0, 1,0,1,2,7,3, 0, 1,7,1,7), 1'b1, 1'b1, 1'b0, 1'b0, FWD_MEM, FWD_RF};
    tbl[10] = '{mk(0,0,0,0,0, 1,0,1,2,7,3, 0, 0,7,1,7), 1'b1, 1'b1, 1'b0, 1'b0, FWD_WB,  FWD_RF};
    tbl[11] = '{mk(0,0,0,0,0, 1,0,1,2,0,0, 0, 1,0,1,0), 1'b1, 1'b1, 1'b0, 1'b0, FWD_RF,  FWD_RF};
    tbl[12] = '{mk(0,0,0,0,0, 1,0,1,2,9,9, 0, 0,9,1,9), 1'b1, 1'b1, 1'b0, 1'b0, FWD_WB,  FWD_WB};
    tbl[13] = '{mk(0,0,0,0,0, 1,0,1,2,4,4, 0, 1,4,1,6), 1'b1, 1'b1, 1'b0, 1'b0, FWD_MEM, FWD_MEM};
    tbl[14] = '{mk(1,1,5,1,0, 1,1,1,5,0,0, 0, 0,0,0,0), 1'b1, 1'b1, 1'b0, 1'b0, FWD_RF,  FWD_RF};
    tbl[15] = '{mk(1,5,1,1,1, 0,1,1,5,0,0, 0, 0,0,0,0), 1'b1, 1'b1, 1'b0, 1'b0, FWD_RF,  FWD_RF};

    // reset state
    do_reset();
    settle();
    chk("rst pc_en", i1.pc_en, 1'b1);
    chk("rst ifid_en", i1.ifid_en, 1'b1);
    chk("rst idex_bubble", i1.idex_bubble, 1'b0);
    chk("rst flush_ifid", i1.flush_ifid, 1'b0);
    chk("rst fwd_a", i1.fwd_a, FWD_RF);
    chk("rst fwd_b", i1.fwd_b, FWD_RF);
    chk("rst stall_count1", i1.stall_count, 0);
    chk("rst stall_count4", i4.stall_count, 0);

    // combinational table on dut1, rst held so the scoreboard stays clear
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      st = tbl[i].s;
      settle();
      chk($sformatf("v%0d pc_en", i), i1.pc_en, tbl[i].pc);
      chk($sformatf("v%0d ifid_en", i), i1.ifid_en, tbl[i].ifid);
      chk($sformatf("v%0d idex_bubble", i), i1.idex_bubble, tbl[i].bub);
      chk($sformatf("v%0d flush_ifid", i), i1.flush_ifid, tbl[i].fl);
      chk($sformatf("v%0d fwd_a", i), i1.fwd_a, tbl[i].fa);
      chk($sformatf("v%0d fwd_b", i), i1.fwd_b, tbl[i].fb);
      tick();
    end

    // LOAD_LAT=1: one bubble, then forward from WB
    do_reset();
    st = ld5_dep;
    settle();
    chk("l1 c0 pc_en", i1.pc_en, 1'b0);
    chk("l1 c0 idex_bubble", i1.idex_bubble, 1'b1);
    tick();
    st = mk(1,5,1,1,1, 0,0,0,0,0,0, 0, 1,5,0,0);
    settle();
    chk("l1 c1 pc_en", i1.pc_en, 1'b1);
    chk("l1 c1 idex_bubble", i1.idex_bubble, 1'b0);
    chk("l1 c1 stall_count", i1.stall_count, 1);
    tick();
    st = mk(0,0,0,0,0, 1,0,1,6,5,1, 0, 0,0,1,5);
    settle();
    chk("l1 c2 fwd_a", i1.fwd_a, FWD_WB);
    chk("l1 c2 fwd_b", i1.fwd_b, FWD_RF);
    chk("l1 c2 stall_count", i1.stall_count, 1);
    tick();

    // LOAD_LAT=3: exactly three stall cycles
    do_reset();
    for (int c = 0; c < 4; c++) begin
      st = (c == 0) ? ld5_dep : dep5_idle;
      settle();
      chk($sformatf("l3 c%0d pc_en", c), i3.pc_en, (c < 3) ? 1'b0 : 1'b1);
      chk($sformatf("l3 c%0d idex_bubble", c), i3.idex_bubble, (c < 3) ? 1'b1 : 1'b0);
      tick();
    end
    st = '0;
    settle();
    chk("l3 stall_count", i3.stall_count, 3);
    tick();

    // LOAD_LAT=3: independent instruction while x5 is pending
    do_reset();
    st = mk(0,0,0,0,0, 1,1,1,5,0,0, 0, 0,0,0,0);
    tick();
    st = mk(1,8,9,1,1, 0,0,0,0,0,0, 0, 0,0,0,0);
    settle();
    chk("indep pc_en", i3.pc_en, 1'b1);
    tick();
    st = dep5_idle;
    settle();
    chk("pend2 pc_en", i3.pc_en, 1'b0);
    tick();
    settle();
    chk("pend1 pc_en", i3.pc_en, 1'b1);
    tick();

    // branch together with a load-use hazard; the killed load leaves no entry
    do_reset();
    st = mk(1,5,1,1,1, 1,1,1,5,0,0, 1, 0,0,0,0);
    settle();
    chk("br flush_ifid", i1.flush_ifid, 1'b1);
    chk("br idex_bubble", i1.idex_bubble, 1'b1);
    chk("br pc_en", i1.pc_en, 1'b1);
    chk("br ifid_en", i1.ifid_en, 1'b1);
    tick();
    st = dep5_idle;
    settle();
    chk("br stall_count", i1.stall_count, 0);
    chk("br killed load pc_en", i3.pc_en, 1'b1);
    chk("br stall_count3", i3.stall_count, 0);
    tick();

    // LOAD_LAT=3: second load to the same rd re-arms without decrementing
    do_reset();
    st = mk(0,0,0,0,0, 1,1,1,5,0,0, 0, 0,0,0,0);
    tick();
    tick();
    for (int c = 0; c < 3; c++) begin
      st = dep5_idle;
      settle();
      chk($sformatf("rearm c%0d pc_en", c), i3.pc_en, (c < 2) ? 1'b0 : 1'b1);
      tick();
    end

    // LOAD_LAT=4: reset in the middle of a stall
    do_reset();
    st = ld5_dep;
    tick();
    st = dep5_idle;
    settle();
    chk("rmid c1 pc_en", i4.pc_en, 1'b0);
    tick();
    rst = 1'b1;
    settle();
    chk("rmid c2 pc_en", i4.pc_en, 1'b0);
    tick();
    rst = 1'b0;
    settle();
    chk("rmid after pc_en", i4.pc_en, 1'b1);
    chk("rmid after stall_count", i4.stall_count, 0);
    tick();

    // LOAD_LAT=4: four stalls; the 2-bit counter saturates at 3
    do_reset();
    for (int c = 0; c < 5; c++) begin
      st = (c == 0) ? ld5_dep : dep5_idle;
      settle();
      chk($sformatf("l4 c%0d pc_en", c), i4.pc_en, (c < 4) ? 1'b0 : 1'b1);
      tick();
    end
    settle();
    chk("l4 stall_count", i4.stall_count, 4);
    chk("sat stall_count", is.stall_count, 3);

    // report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
